// File: rtl/issue_scoreboard.sv
// issue_scoreboard: register-hazard scheduler gating decode->execute issue on pending multi-cycle writes.
// Optional SCOREBOARD_BYPASS_EN lets a same-cycle writeback clear its hazard and capacity slot.
module issue_scoreboard #(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             valid_out,
    input  logic             ready_in,
    input  logic             flush,
    input  logic [5:0]       rs1_addr,
    input  logic [5:0]       rs2_addr,
    input  logic [5:0]       rs3_addr,
    input  logic             rs1_access,
    input  logic             rs2_access,
    input  logic             rs3_access,
    input  logic [5:0]       rd_addr,
    input  logic             rd_access,
    input  logic             wb_valid,
    input  logic [5:0]       wb_addr,
    output logic             stall,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             busy,
    output logic             wb_err
);
    logic [63:0] pending, pending_eff, set_mask, clr_mask;
    logic [CNT_W-1:0] cnt_eff;
    logic wb_hit, hazard, cap_stall, issue, set_rd;

    assign wb_hit = wb_valid && pending[wb_addr];
`ifdef SCOREBOARD_BYPASS_EN
    assign pending_eff = wb_valid ? pending & ~(64'd1 << wb_addr) : pending;
    assign cnt_eff = pending_cnt - CNT_W'(wb_hit);
`else
    assign pending_eff = pending;
    assign cnt_eff = pending_cnt;
`endif
    assign hazard = (rs1_access && pending_eff[rs1_addr]) || (rs2_access && pending_eff[rs2_addr]) ||
                    (rs3_access && pending_eff[rs3_addr]) || (rd_access && pending_eff[rd_addr]);
    assign cap_stall = rd_access && rd_addr != 6'd0 && cnt_eff == CNT_W'(MAX_PENDING);
    assign stall = valid_in && !flush && (hazard || cap_stall);
    assign valid_out = valid_in && !flush && !stall;
    assign ready_out = flush ? 1'b1 : ready_in && !stall;
    assign issue = valid_out && ready_in;
    assign set_rd = issue && rd_access && rd_addr != 6'd0;
    assign set_mask = set_rd ? 64'd1 << rd_addr : 64'd0;
    assign clr_mask = wb_hit ? 64'd1 << wb_addr : 64'd0;
    assign busy = pending_cnt != '0;

    // Set is applied after clear so a same-register issue/retire keeps the bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            pending_cnt <= '0;
            wb_err <= 1'b0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            pending_cnt <= pending_cnt + CNT_W'(set_rd && !wb_hit) - CNT_W'(wb_hit && !set_rd);
            if (wb_valid && !wb_hit) wb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed and random stimulus checked against a queue-based model of outstanding writes.
module tb_issue_scoreboard;
    localparam int MAXP = 4;
    localparam int CW = $clog2(MAXP + 1);
`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 0, reset = 1;
    logic valid_in = 0, ready_in = 0, flush = 0;
    logic [5:0] rs1_addr = 0, rs2_addr = 0, rs3_addr = 0, rd_addr = 0, wb_addr = 0;
    logic rs1_access = 0, rs2_access = 0, rs3_access = 0, rd_access = 0, wb_valid = 0;
    logic ready_out, valid_out, stall, busy, wb_err;
    logic [CW-1:0] pending_cnt;
    int checks = 0, errors = 0;
    int outstanding[$];
    bit err_m = 0;
    int pool[8] = '{0, 1, 2, 5, 7, 32, 33, 63};

    issue_scoreboard #(.MAX_PENDING(MAXP)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out), .valid_out(valid_out),
        .ready_in(ready_in), .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs3_addr(rs3_addr),
        .rs1_access(rs1_access), .rs2_access(rs2_access), .rs3_access(rs3_access), .rd_addr(rd_addr),
        .rd_access(rd_access), .wb_valid(wb_valid), .wb_addr(wb_addr), .stall(stall),
        .pending_cnt(pending_cnt), .busy(busy), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_pend(input int a);
        foreach (outstanding[i]) if (outstanding[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit blocked(input int a, input bit wv, input int wa);
        return is_pend(a) && !(BYP && wv && a == wa);
    endfunction

    task automatic step(input bit vi, input bit ri, input bit fl, input int a1, input bit x1,
                        input int a2, input bit x2, input int a3, input bit x3,
                        input int ad, input bit xd, input bit wv, input int wa);
        bit hit, haz, cap, e_stall, e_vo, e_ro;
        int cnt_eff;
        @(negedge clk);
        valid_in = vi; ready_in = ri; flush = fl;
        rs1_addr = 6'(a1); rs1_access = x1; rs2_addr = 6'(a2); rs2_access = x2;
        rs3_addr = 6'(a3); rs3_access = x3; rd_addr = 6'(ad); rd_access = xd;
        wb_valid = wv; wb_addr = 6'(wa);
        #1;
        chk("pending_cnt", int'(pending_cnt), outstanding.size());
        chk("busy", int'(busy), int'(outstanding.size() != 0));
        chk("wb_err", int'(wb_err), int'(err_m));
        hit = wv && is_pend(wa);
        haz = (x1 && blocked(a1, wv, wa)) || (x2 && blocked(a2, wv, wa)) ||
              (x3 && blocked(a3, wv, wa)) || (xd && blocked(ad, wv, wa));
        cnt_eff = outstanding.size() - ((BYP && hit) ? 1 : 0);
        cap = xd && ad != 0 && cnt_eff == MAXP;
        e_stall = vi && !fl && (haz || cap);
        e_vo = vi && !fl && !e_stall;
        e_ro = fl ? 1'b1 : (ri && !e_stall);
        chk("stall", int'(stall), int'(e_stall));
        chk("valid_out", int'(valid_out), int'(e_vo));
        chk("ready_out", int'(ready_out), int'(e_ro));
        if (hit)
            foreach (outstanding[i]) if (outstanding[i] == wa) begin outstanding.delete(i); break; end
        if (wv && !hit) err_m = 1'b1;
        if (e_vo && ri && xd && ad != 0) outstanding.push_back(ad);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; valid_in = 1; flush = 0; wb_valid = 1; wb_addr = 6'd5;
        #1;
        chk("rst_cnt", int'(pending_cnt), 0);
        chk("rst_err", int'(wb_err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_valid_out", int'(valid_out), 1);
        outstanding.delete();
        err_m = 0;
        @(posedge clk); #1;
        chk("rst_wb_ignored", int'(pending_cnt), 0);
        chk("rst_wb_err_ignored", int'(wb_err), 0);
        @(negedge clk);
        valid_in = 0; wb_valid = 0; reset = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        do_reset();
        // hazard on rd=5 retired by writeback
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
        step(1, 1, 0, 5, 1, 0, 0, 0, 0, 8, 0, 0, 0);
        step(1, 1, 0, 5, 1, 0, 0, 0, 0, 8, 0, 1, 5);
        step(1, 1, 0, 5, 1, 0, 0, 0, 0, 8, 0, 0, 0);
        // x0 and f0 destinations
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 32, 1, 0, 0);
        step(1, 1, 0, 0, 0, 32, 1, 0, 0, 9, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32);
        // capacity
        for (int r = 1; r <= 4; r++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, r, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0);
        step(1, 1, 0, 10, 1, 0, 0, 0, 0, 6, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 6, 1, 1, 2);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 6, 1, 0, 0);
        // WAW on x7
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 7, 1, 1, 7);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0);
        // flush of a hazardous instruction, then stray writeback
        step(1, 0, 1, 3, 1, 0, 0, 0, 0, 12, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset mid-run, stalled source issues right after
        step(1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        step(1, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            int wa;
            if ($urandom_range(99) == 0) begin
                do_reset();
                continue;
            end
            wa = (outstanding.size() != 0 && $urandom_range(99) < 85) ?
                 outstanding[$urandom_range(outstanding.size() - 1)] : pool[$urandom_range(7)];
            step($urandom_range(9) < 8, $urandom_range(9) < 8, $urandom_range(19) == 0,
                 pool[$urandom_range(7)], 1'($urandom), pool[$urandom_range(7)], 1'($urandom),
                 pool[$urandom_range(7)], $urandom_range(3) == 0,
                 pool[$urandom_range(7)], $urandom_range(3) != 0,
                 $urandom_range(2) == 0, wa);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
